alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for unsigned MULTU/DIVU on the shared 32-bit ALU (no own adder).
//  Each iteration drives ALU input1/input2/aluCtr and consumes aluRes, producing a HI/LO pair.
//  Sits beside the EX stage. The pipeline stalls while busy=1; ALU input muxing is the EX stage's job.
// PARAMETERS
//  WIDTH   32  operand width; must equal the ALU width
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      op request; accepted only in IDLE
//  op_div     in   1      0=MULTU, 1=DIVU; sampled with start
//  opa        in   WIDTH  multiplicand / dividend; sampled with start
//  opb        in   WIDTH  multiplier / divisor; sampled with start
//  abort      in   1      pipeline flush; cancels any op in progress
//  alu_in1    out  WIDTH  to ALU input1
//  alu_in2    out  WIDTH  to ALU input2
//  alu_ctr    out  4      to ALU aluCtr
//  alu_res    in   WIDTH  from ALU aluRes (combinational, same cycle)
//  busy       out  1      high from the cycle after accept through the DONE cycle
//  done       out  1      one-cycle pulse; hi/lo valid
//  hi         out  WIDTH  MULTU: upper product; DIVU: remainder
//  lo         out  WIDTH  MULTU: lower product; DIVU: quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, hi, lo, cnt = 0; alu_* = 0 (alu_ctr=AND).
//  FSM states: IDLE, MUL, DIV, DONE.
//  IDLE, start=1:
//    load acc=0, q=opb (mul) or opa (div), m=opa (mul) or opb (div), cnt=0.
//    Next state is MUL or DIV.
//    Exception, op_div=1 and opb=0: go straight to DONE with hi=opa, lo=all-ones.
//  MUL, per cycle:
//    alu_in1=acc; alu_in2 = q[0] ? m : 0; alu_ctr=ADD.
//    carry = (alu_res < acc), local unsigned compare.
//    {acc,q} <= {carry, alu_res, q[WIDTH-1:1]}.
//  DIV, per cycle (restoring):
//    r = {acc[WIDTH-2:0], q[WIDTH-1]}; msb = acc[WIDTH-1].
//    alu_in1=r; alu_in2=m; alu_ctr=SUB.
//    qb = msb | ~(r < m).
//    acc <= qb ? alu_res : r; q <= {q[WIDTH-2:0], qb}.
//  cnt increments every MUL/DIV cycle. At cnt=WIDTH-1 -> DONE.
//  DONE: hi<=acc, lo<=q, done=1 for exactly one cycle, then IDLE.
//  Latency: start accepted at edge N -> done high in cycle N+WIDTH+1 (33 for WIDTH=32).
//    Divide-by-zero: done in cycle N+1.
//  hi/lo hold their last result until the next DONE; they are not cleared by a new start.
//  start while not IDLE is ignored; there is no queue.
//  Start in the DONE cycle is ignored; the requester re-asserts it in IDLE.
//  abort (any state): next edge -> IDLE, busy=0, done=0. hi/lo keep their old values.
//    abort and start together in IDLE: abort wins, op not accepted.
//  Outside MUL/DIV: alu_in1=alu_in2=0, alu_ctr=AND. The EX stage ignores them.
//  Reset asserted mid-op: immediate return to reset values; no done pulse.
// STRUCTURE
//  Package alu_pkg: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110,
//    ALU_SLT=4'b0111, ALU_NOR=4'b1100; state enum.
//  Single module; FSM and datapath registers inline.
//  Bench instantiates the real ALU and loops alu_* through it. No sub-module.
// TESTING
//  7 MULTU 6 -> done at cycle 33; hi=0, lo=0x0000002A; busy high cycles 1..33.
//  0xFFFFFFFF MULTU 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises carry path).
//  100 DIVU 7 -> lo=14, hi=2.
//  0x80000000 DIVU 3 -> lo=0x2AAAAAAA, hi=2.
//  0xFFFFFFFF DIVU 1 -> lo=0xFFFFFFFF, hi=0 (exercises msb path).
//  5 DIVU 0 -> done next cycle; hi=5, lo=0xFFFFFFFF.
//  start pulsed at cycle 10 of a MULTU -> ignored; original result unchanged.
//  abort at cycle 10 -> IDLE, no done, hi/lo unchanged.
//  rst_n low at cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the MULTU/DIVU sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bus plus the borrowed-ALU loop of the MULTU/DIVU sequencer.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             abort;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] alu_res;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Handshake: start is taken on a rising edge only while the sequencer is
    // idle and abort is low; the requester holds off (busy=1) until done, a
    // single-cycle pulse during which hi/lo carry the new result. The master
    // side also owns the ALU, so it returns alu_res in the same cycle.
    modport master (
        output start, op_div, opa, opb, abort, alu_res,
        input  alu_in1, alu_in2, alu_ctr, busy, done, hi, lo
    );

    modport slave (
        input  start, op_div, opa, opb, abort, alu_res,
        output alu_in1, alu_in2, alu_ctr, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the EX-stage ALU
// for its add/subtract each iteration; one result bit per cycle.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_muldiv_seq_if.slave   bus,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] rem_shift;
    logic             carry;
    logic             qbit;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        alu_in1   = '0;
        alu_in2   = '0;
        alu_ctr   = ALU_AND;
        rem_shift = {acc[WIDTH-2:0], q[WIDTH-1]};
        carry     = 1'b0;
        qbit      = 1'b0;
        acc_nxt   = acc;
        q_nxt     = q;
        case (state)
            MUL: begin
                alu_in1 = acc;
                alu_in2 = q[0] ? m : '0;
                alu_ctr = ALU_ADD;
                // The ALU has no carry-out; an unsigned wrap shows up as a smaller sum.
                carry   = (bus.alu_res < acc);
                {acc_nxt, q_nxt} = {carry, bus.alu_res, q[WIDTH-1:1]};
            end
            DIV: begin
                alu_in1 = rem_shift;
                alu_in2 = m;
                alu_ctr = ALU_SUB;
                // A bit shifted out of acc means the true remainder is >= 2**WIDTH > m.
                qbit    = acc[WIDTH-1] | ~(rem_shift < m);
                acc_nxt = qbit ? bus.alu_res : rem_shift;
                q_nxt   = {q[WIDTH-2:0], qbit};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        q      <= bus.op_div ? bus.opa : bus.opb;
                        m      <= bus.op_div ? bus.opb : bus.opa;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        if (bus.op_div && (bus.opb == '0)) begin
                            hi_r   <= bus.opa;
                            lo_r   <= '1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= bus.op_div ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CNT_W'(1);
                    // Results are captured on entry to DONE so hi/lo are valid with done.
                    if (cnt == LAST) begin
                        hi_r   <= acc_nxt;
                        lo_r   <= q_nxt;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_in1 = alu_in1;
    assign bus.alu_in2 = alu_in2;
    assign bus.alu_ctr = alu_ctr;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign dbg_state   = state;

endmodule
